// File: rtl/self_stream_pkg.sv
// Shared SELF stream constants and helpers.
// Used by the AXI/SELF bridge buffers on both kernel edges.
package self_stream_pkg;

    // Cycles between upstream seeing stop and dropping valid.
    localparam int unsigned SelfStopLatency = 1;

    // Fill level at which stop must be raised to keep skid slots free.
    function automatic int unsigned stop_threshold(input int unsigned depth);
        return depth - SelfStopLatency;
    endfunction

endpackage

// File: rtl/axi_output_buffer_ram.sv
// Storage for the output buffer: sync write, async read, no reset.
// Small enough to land in distributed RAM.
module axi_output_buffer_ram #(
    parameter int unsigned DataWidth = 16,
    parameter int unsigned IndexSize = 2
) (
    input  logic                 clk,
    input  logic                 we,
    input  logic [IndexSize-1:0] waddr,
    input  logic [DataWidth-1:0] wdata,
    input  logic [IndexSize-1:0] raddr,
    output logic [DataWidth-1:0] rdata
);

    localparam int unsigned Depth = 1 << IndexSize;

    logic [DataWidth-1:0] mem_q [Depth];

    // Write port: one entry per cycle when enabled.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/axi_output_buffer.sv
// SELF valid/stop stream to AXI-stream valid/ready converter.
// FIFO absorbs the one-cycle stop latency and AXI back-pressure.
module axi_output_buffer
    import self_stream_pkg::*;
#(
    parameter int unsigned DataWidth       = 16,
    parameter int unsigned BufferIndexSize = 2
) (
    input  logic                 clk,
    input  logic                 srst,
    input  logic [DataWidth-1:0] dataIn,
    input  logic                 dataInValid,
    output logic                 dataInStop,
    output logic [DataWidth-1:0] axiDataOut,
    output logic                 axiValid,
    input  logic                 axiReady
);

    localparam int unsigned Depth = 1 << BufferIndexSize;
    localparam int unsigned CntW  = BufferIndexSize + 1;
    localparam int unsigned Stop  = stop_threshold(Depth);

    localparam logic [CntW-1:0] DepthC = CntW'(Depth);
    localparam logic [CntW-1:0] StopC  = CntW'(Stop);
    localparam logic [CntW-1:0] OneC   = CntW'(1);
    localparam logic [BufferIndexSize-1:0] PtrOne =
        BufferIndexSize'(1);

    logic [CntW-1:0]            count_q, count_d;
    logic [BufferIndexSize-1:0] wr_ptr_q, wr_ptr_d;
    logic [BufferIndexSize-1:0] rd_ptr_q, rd_ptr_d;

    logic                 push;
    logic                 pop;
    logic [DataWidth-1:0] head;

    // Outputs come from registered state only.
    assign axiValid   = (count_q != '0);
    assign dataInStop = (count_q >= StopC);
    assign axiDataOut = axiValid ? head : '0;

    // Handshake decode and next pointer/count values.
    always_comb begin
        push     = dataInValid && (count_q != DepthC);
        pop      = axiValid && axiReady;
        count_d  = count_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PtrOne;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PtrOne;
        end
        unique case ({push, pop})
            2'b10:   count_d = count_q + OneC;
            2'b01:   count_d = count_q - OneC;
            default: count_d = count_q;
        endcase
    end

    // State registers; reset discards every buffered word.
    always_ff @(posedge clk) begin
        if (srst) begin
            count_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            count_q  <= count_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    axi_output_buffer_ram #(
        .DataWidth (DataWidth),
        .IndexSize (BufferIndexSize)
    ) u_ram (
        .clk   (clk),
        .we    (push && !srst),
        .waddr (wr_ptr_q),
        .wdata (dataIn),
        .raddr (rd_ptr_q),
        .rdata (head)
    );

endmodule

// File: tb/tb_axi_output_buffer.sv
// Directed and randomized checks for axi_output_buffer.
// Two instances: depth 4 for directed steps, depth 2 for wrap stress.
module tb_axi_output_buffer;

    logic        clk = 1'b0;
    logic        srst, dv, stop, av, ar;
    logic [15:0] din, dout;
    logic        srst2, dv2, stop2, av2, ar2;
    logic [15:0] din2, dout2;

    int n_chk  = 0;
    int n_fail = 0;
    int mcount = 0;
    int ovf_cnt = 0;
    int pops = 0;
    int ovf_before;
    bit stop_prev;
    logic [15:0] q[$];

    always #5 clk = ~clk;

    axi_output_buffer #(.DataWidth(16), .BufferIndexSize(2)) u0 (
        .clk(clk), .srst(srst), .dataIn(din), .dataInValid(dv),
        .dataInStop(stop), .axiDataOut(dout), .axiValid(av),
        .axiReady(ar)
    );

    axi_output_buffer #(.DataWidth(16), .BufferIndexSize(1)) u1 (
        .clk(clk), .srst(srst2), .dataIn(din2), .dataInValid(dv2),
        .dataInStop(stop2), .axiDataOut(dout2), .axiValid(av2),
        .axiReady(ar2)
    );

    // Reference occupancy of u0, used to flag overflow attempts.
    always @(posedge clk) begin
        if (srst) begin
            mcount <= 0;
        end else begin
            if (dv && mcount == 4) ovf_cnt <= ovf_cnt + 1;
            mcount <= mcount + ((dv && mcount < 4) ? 1 : 0)
                             - ((mcount != 0 && ar) ? 1 : 0);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        srst = 1; dv = 1; din = 16'h1234; ar = 0;
        srst2 = 1; dv2 = 0; din2 = 0; ar2 = 0;

        // Reset held two cycles with valid high.
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("rst_valid", av, 0);
            chk("rst_data", dout, 0);
            chk("rst_stop", stop, 0);
        end
        srst = 0; srst2 = 0; dv = 0;
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("post_rst_valid", av, 0);
            chk("post_rst_data", dout, 0);
        end

        // Streaming at full rate.
        ar = 1;
        for (int i = 1; i <= 16; i++) begin
            din = 16'(i); dv = 1;
            tick();
            chk("stream_valid", av, 1);
            chk("stream_data", dout, 32'(i));
            chk("stream_stop", stop, 0);
        end
        dv = 0;
        tick();
        chk("stream_end_valid", av, 0);
        chk("stream_no_ovf", ovf_cnt, 0);

        // Fill until stop, then skid word.
        ar = 0;
        for (int i = 0; i < 4; i++) begin
            din = 16'h00A0 + 16'(i); dv = 1;
            tick();
            chk("fill_stop", stop, (i >= 2) ? 1 : 0);
            chk("fill_head", dout, 32'h00A0);
        end
        dv = 0;
        tick();
        chk("stall_head", dout, 32'h00A0);
        chk("stall_valid", av, 1);
        chk("fill_no_ovf", ovf_cnt, 0);

        // Drain in order; stop falls once count drops below 3.
        ar = 1;
        for (int i = 1; i < 4; i++) begin
            tick();
            chk("drain_data", dout, 32'h00A0 + 32'(i));
            chk("drain_stop", stop, (i == 1) ? 1 : 0);
        end
        tick();
        chk("drain_empty", av, 0);
        chk("drain_empty_data", dout, 0);

        // Refill to full, then push and pop together.
        ar = 0;
        for (int i = 0; i < 4; i++) begin
            din = 16'h00B0 + 16'(i); dv = 1;
            tick();
        end
        dv = 0;
        tick();
        chk("full_stop", stop, 1);
        ovf_before = ovf_cnt;
        ar = 1; dv = 1; din = 16'h00EE;
        tick();
        dv = 0;
        chk("full_pop_data", dout, 32'h00B1);
        chk("full_stop_after", stop, 1);
        chk("full_ovf_flag", ovf_cnt - ovf_before, 1);
        for (int i = 2; i < 4; i++) begin
            tick();
            chk("full_drain", dout, 32'h00B0 + 32'(i));
        end
        tick();
        chk("full_refused", av, 0);

        // Reset mid-operation with three words held.
        ar = 0;
        for (int i = 0; i < 3; i++) begin
            din = 16'h00C0 + 16'(i); dv = 1;
            tick();
        end
        dv = 0;
        chk("mid_stop", stop, 1);
        srst = 1;
        tick();
        srst = 0;
        chk("mid_rst_valid", av, 0);
        chk("mid_rst_stop", stop, 0);
        chk("mid_rst_data", dout, 0);
        din = 16'h0055; dv = 1;
        tick();
        dv = 0; ar = 1;
        chk("mid_first_valid", av, 1);
        chk("mid_first_data", dout, 32'h0055);
        tick();
        chk("mid_after_valid", av, 0);

        // Depth-2 random traffic with compliant upstream.
        stop_prev = 0;
        for (int c = 0; c < 1000; c++) begin
            chk("wrap_valid", av2, (q.size() != 0) ? 1 : 0);
            dv2 = ($urandom_range(3) != 0) && !stop_prev;
            stop_prev = stop2;
            din2 = 16'($urandom);
            ar2 = ($urandom_range(3) != 0);
            if (av2 && ar2 && q.size() != 0) begin
                chk("wrap_data", dout2, q.pop_front());
                pops++;
            end
            if (dv2) q.push_back(din2);
            tick();
        end
        dv2 = 0; ar2 = 1;
        for (int c = 0; c < 4; c++) begin
            if (av2 && q.size() != 0) begin
                chk("wrap_tail", dout2, q.pop_front());
                pops++;
            end
            tick();
        end
        chk("wrap_drained", av2, (q.size() != 0) ? 1 : 0);
        chk("wrap_count", (pops >= 200) ? 1 : 0, 1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
